// File: rtl/seg7_scan_rx.sv
// Receive side of the scanned 7-segment display bus: synchronise, filter, decode and publish 4-digit frames.
// Optional build macro SEG7RX_CHANGE_ONLY_EN suppresses VALID for frames identical to the one already published.
module seg7_scan_rx #(
    parameter int STABLE_CNT  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  LED,
    input  logic [3:0]  SA,
    output logic [15:0] DIGITS,
    output logic [3:0]  DP,
    output logic        VALID,
    output logic        ERR
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT - 1);

    typedef enum logic [1:0] {IDLE, DWELL, HELD} state_t;

    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   seg_decode = 4'd0;
            7'h06:   seg_decode = 4'd1;
            7'h5B:   seg_decode = 4'd2;
            7'h4F:   seg_decode = 4'd3;
            7'h66:   seg_decode = 4'd4;
            7'h6D:   seg_decode = 4'd5;
            7'h7D:   seg_decode = 4'd6;
            7'h07:   seg_decode = 4'd7;
            7'h7F:   seg_decode = 4'd8;
            7'h6F:   seg_decode = 4'd9;
            7'h00:   seg_decode = 4'hF;
            default: seg_decode = 4'hE;
        endcase
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        case (oh)
            4'b0010: onehot_idx = 2'd1;
            4'b0100: onehot_idx = 2'd2;
            4'b1000: onehot_idx = 2'd3;
            default: onehot_idx = 2'd0;
        endcase
    endfunction

    logic [11:0]      sync_q [SYNC_STAGES];
    logic [11:0]      prev_q;
    logic [11:0]      s;
    logic             changed;
    logic [7:0]       cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             capture;
    logic [3:0]       s_sa;
    logic [7:0]       s_led;
    logic [3:0]       dec;
    logic [1:0]       idx;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [3:0]       sdp_q, sdp_d;
    logic [3:0]       seen_q, seen_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dp_q, dp_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
`ifdef SEG7RX_CHANGE_ONLY_EN
    logic             first_q, first_d;
`endif

    assign s       = sync_q[SYNC_STAGES-1];
    assign changed = (s != prev_q);
    assign s_sa    = s[11:8];
    assign s_led   = s[7:0];
    assign dec     = seg_decode(s_led[6:0]);
    assign idx     = onehot_idx(s_sa);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {SA, LED};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= s;
        end
    end

    always_comb begin
        if (changed)
            cnt_d = '0;
        else if (cnt_q == CNT_MAX)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;
    end

    // HELD blocks a second capture until the bus moves again.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE:  state_d = DWELL;
            DWELL: begin
                if (!changed && cnt_q == CNT_MAX) begin
                    capture = 1'b1;
                    state_d = HELD;
                end
            end
            HELD:  if (changed) state_d = DWELL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        seen_d   = seen_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
`ifdef SEG7RX_CHANGE_ONLY_EN
        first_d  = first_q;
`endif
        if (seen_q == 4'hF) begin
            seen_d = '0;
`ifdef SEG7RX_CHANGE_ONLY_EN
            if (first_q || ({shadow_q, sdp_q} != {digits_q, dp_q})) begin
                digits_d = shadow_q;
                dp_d     = sdp_q;
                valid_d  = 1'b1;
                first_d  = 1'b0;
            end
`else
            digits_d = shadow_q;
            dp_d     = sdp_q;
            valid_d  = 1'b1;
`endif
        end
        // Capture after the publish clear so a same-cycle capture keeps only its own seen bit.
        if (capture && s_sa != 4'b0000) begin
            if (!$onehot(s_sa)) begin
                err_d = 1'b1;
            end else begin
                shadow_d[idx] = dec;
                sdp_d[idx]    = s_led[7];
                seen_d[idx]   = 1'b1;
                if (dec == 4'hE) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            sdp_q    <= '0;
            seen_q   <= '0;
            digits_q <= 16'hFFFF;
            dp_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG7RX_CHANGE_ONLY_EN
            first_q  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            seen_q   <= seen_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef SEG7RX_CHANGE_ONLY_EN
            first_q  <= first_d;
`endif
        end
    end

    assign DIGITS = digits_q;
    assign DP     = dp_q;
    assign VALID  = valid_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Directed bench for seg7_scan_rx: drives scanned SA/LED frames and checks published DIGITS/DP/VALID/ERR.
module tb_seg7_scan_rx;

    logic        CLK;
    logic        RESET;
    logic [7:0]  LED;
    logic [3:0]  SA;
    logic [15:0] DIGITS;
    logic [3:0]  DP;
    logic        VALID;
    logic        ERR;

    int checks;
    int errors;

    int          valid_cnt;
    int          err_cnt;
    logic [15:0] last_digits;
    logic [3:0]  last_dp;

    seg7_scan_rx #(.STABLE_CNT(4), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .LED(LED), .SA(SA),
        .DIGITS(DIGITS), .DP(DP), .VALID(VALID), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse monitor, sampled on the falling edge
    initial begin
        valid_cnt   = 0;
        err_cnt     = 0;
        last_digits = 16'h0000;
        last_dp     = 4'h0;
    end
    always @(negedge CLK) begin
        if (VALID === 1'b1) begin
            valid_cnt   = valid_cnt + 1;
            last_digits = DIGITS;
            last_dp     = DP;
        end
        if (ERR === 1'b1) err_cnt = err_cnt + 1;
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        SA    = 4'b0000;
        LED   = 8'h00;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic drive(input logic [3:0] sa, input logic [7:0] led, input int n);
        SA  = sa;
        LED = led;
        repeat (n) @(negedge CLK);
    endtask

    task automatic scan4(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                         input logic [7:0] l3, input int dwell, input int gap);
        drive(4'b0001, l0, dwell);
        if (gap > 0) drive(4'b0000, 8'h00, gap);
        drive(4'b0010, l1, dwell);
        if (gap > 0) drive(4'b0000, 8'h00, gap);
        drive(4'b0100, l2, dwell);
        if (gap > 0) drive(4'b0000, 8'h00, gap);
        drive(4'b1000, l3, dwell);
        drive(4'b0000, 8'h00, 12);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        SA    = 4'b0000;
        LED   = 8'h00;
        repeat (2) @(negedge CLK);
        checks++; if (DIGITS !== 16'hFFFF) begin errors++; $display("FAIL reset_digits got=%h exp=ffff", DIGITS); end
        checks++; if (DP !== 4'h0) begin errors++; $display("FAIL reset_dp got=%b exp=0000", DP); end
        checks++; if (VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", VALID); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ERR); end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_basic_frame();
        int v0, e0;
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        scan4(8'h3F, 8'h6D, 8'hFF, 8'h00, 8, 0);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_digits !== 16'hF850) begin errors++; $display("FAIL basic_digits got=%h exp=f850", last_digits); end
        checks++; if (last_dp !== 4'b0100) begin errors++; $display("FAIL basic_dp got=%b exp=0100", last_dp); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL basic_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_short_dwell();
        int v0;
        do_reset();
        v0 = valid_cnt;
        scan4(8'h3F, 8'h6D, 8'hFF, 8'h00, 3, 0);
        scan4(8'h3F, 8'h6D, 8'hFF, 8'h00, 3, 0);
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL short_dwell_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (DIGITS !== 16'hFFFF) begin errors++; $display("FAIL short_dwell_digits got=%h exp=ffff", DIGITS); end
        v0 = valid_cnt;
        scan4(8'h3F, 8'h6D, 8'hFF, 8'h00, 5, 0);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL dwell5_valid got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_digits !== 16'hF850) begin errors++; $display("FAIL dwell5_digits got=%h exp=f850", last_digits); end
    endtask

    task automatic test_errors();
        int v0, e0;
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        scan4(8'h3F, 8'h06, 8'h12, 8'h4F, 8, 0);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL bad_seg_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (last_digits !== 16'h3E10) begin errors++; $display("FAIL bad_seg_digits got=%h exp=3e10", last_digits); end
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL bad_seg_valid got=%0d exp=1", valid_cnt - v0); end
        v0 = valid_cnt; e0 = err_cnt;
        drive(4'b0011, 8'h3F, 8);
        drive(4'b0100, 8'h66, 8);
        drive(4'b1000, 8'h07, 8);
        drive(4'b0000, 8'h00, 12);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL multi_sa_err got=%0d exp=1", err_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL multi_sa_seen got=%0d exp=0", valid_cnt - v0); end
        drive(4'b0001, 8'h6F, 8);
        drive(4'b0010, 8'h7D, 8);
        drive(4'b0000, 8'h00, 12);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL multi_sa_complete got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_digits !== 16'h7469) begin errors++; $display("FAIL multi_sa_digits got=%h exp=7469", last_digits); end
    endtask

    task automatic test_blanking();
        int v0, e0;
        do_reset();
        v0 = valid_cnt; e0 = err_cnt;
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66, 8, 6);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL blank_valid got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_digits !== 16'h4321) begin errors++; $display("FAIL blank_digits got=%h exp=4321", last_digits); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL blank_err got=%0d exp=0", err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        do_reset();
        scan4(8'h3F, 8'h6D, 8'hFF, 8'h00, 8, 0);
        v0 = valid_cnt;
        drive(4'b0001, 8'h3F, 8);
        drive(4'b0010, 8'h6D, 8);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (DIGITS !== 16'hFFFF) begin errors++; $display("FAIL midrst_digits got=%h exp=ffff", DIGITS); end
        checks++; if (DP !== 4'h0) begin errors++; $display("FAIL midrst_dp got=%b exp=0000", DP); end
        RESET = 1'b0;
        SA    = 4'b0000;
        LED   = 8'h00;
        repeat (2) @(negedge CLK);
        drive(4'b0100, 8'h7F, 8);
        drive(4'b1000, 8'h6F, 8);
        drive(4'b0001, 8'h7D, 8);
        drive(4'b0010, 8'h07, 8);
        drive(4'b0000, 8'h00, 12);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_valid got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_digits !== 16'h9876) begin errors++; $display("FAIL midrst_new_digits got=%h exp=9876", last_digits); end
        checks++; if (last_dp !== 4'h0) begin errors++; $display("FAIL midrst_new_dp got=%b exp=0000", last_dp); end
    endtask

    task automatic test_back_to_back();
        int v0, exp_v;
        do_reset();
        v0 = valid_cnt;
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66, 8, 0);
        scan4(8'h06, 8'h5B, 8'h4F, 8'h66, 8, 0);
`ifdef SEG7RX_CHANGE_ONLY_EN
        exp_v = 1;
`else
        exp_v = 2;
`endif
        checks++; if (valid_cnt - v0 !== exp_v) begin errors++; $display("FAIL repeat_valid got=%0d exp=%0d", valid_cnt - v0, exp_v); end
        checks++; if (DIGITS !== 16'h4321) begin errors++; $display("FAIL repeat_digits got=%h exp=4321", DIGITS); end
        v0 = valid_cnt;
        scan4(8'h5B, 8'h5B, 8'h4F, 8'h66, 8, 0);
        checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL change_valid got=%0d exp=1", valid_cnt - v0); end
        checks++; if (last_digits !== 16'h4322) begin errors++; $display("FAIL change_digits got=%h exp=4322", last_digits); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        SA     = 4'b0000;
        LED    = 8'h00;
        test_reset();
        test_basic_frame();
        test_short_dwell();
        test_errors();
        test_blanking();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
